// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU byte bus: synchronous byte RAM plus an IO page
// at 0x30000 with TX/RX byte FIFOs, status, cycle-counter snapshot and halt register.
module cpu_mem_responder #(
  parameter int unsigned RAM_ADDR_W = 17,
  parameter int unsigned TX_DEPTH   = 8,
  parameter int unsigned RX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halt,
  output logic [7:0]  halt_code,
  output logic        overflow
);

  localparam int unsigned TxPtrW = $clog2(TX_DEPTH);
  localparam int unsigned TxCntW = TxPtrW + 1;
  localparam int unsigned RxPtrW = $clog2(RX_DEPTH);
  localparam int unsigned RxCntW = RxPtrW + 1;

  localparam logic [TxCntW-1:0] TxFullCnt   = TxCntW'(TX_DEPTH);
  localparam logic [TxCntW-1:0] TxAlmostCnt = TxCntW'(TX_DEPTH - 2);
  localparam logic [RxCntW-1:0] RxFullCnt   = RxCntW'(RX_DEPTH);

  localparam logic [2:0] RegFifo   = 3'd0;
  localparam logic [2:0] RegStatus = 3'd1;
  localparam logic [2:0] RegCnt0   = 3'd4;
  localparam logic [2:0] RegCnt1   = 3'd5;
  localparam logic [2:0] RegCnt2   = 3'd6;
  localparam logic [2:0] RegCnt3   = 3'd7;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic                  is_io;
  logic [2:0]            io_reg;
  logic                  io_rd;
  logic                  io_wr;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic                  ram_we;

  assign is_io    = (mem_a[17:16] == 2'b11);
  assign io_reg   = mem_a[2:0];
  assign io_rd    = is_io & ~mem_wr;
  assign io_wr    = is_io & mem_wr;
  assign ram_addr = mem_a[RAM_ADDR_W-1:0];
  assign ram_we   = ~is_io & mem_wr;

  // Upper address bits are deliberately ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^mem_a;

  logic tx_push;
  logic rx_pop_req;
  logic snap_latch;
  logic halt_wr;

  assign tx_push    = io_wr & (io_reg == RegFifo);
  assign halt_wr    = io_wr & (io_reg == RegCnt0);
  assign rx_pop_req = io_rd & (io_reg == RegFifo);
  assign snap_latch = io_rd & (io_reg == RegCnt0);

  // ---------------------------------------------------------------------------
  // RAM (not reset)
  // ---------------------------------------------------------------------------
  logic [7:0] ram [2**RAM_ADDR_W];

  always_ff @(posedge clk_in) begin
    if (ram_we) begin
      ram[ram_addr] <= mem_dout;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]        tx_mem [TX_DEPTH];
  logic [TxPtrW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [TxPtrW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TxCntW-1:0] tx_cnt_q, tx_cnt_d;
  logic              tx_full;
  logic              tx_accept;
  logic              tx_pop;
  logic              overflow_q, overflow_d;

  assign tx_full   = (tx_cnt_q == TxFullCnt);
  assign tx_valid  = (tx_cnt_q != '0);
  assign tx_pop    = tx_valid & tx_ready;
  // A push into a full FIFO is dropped even when a pop happens in the same cycle.
  assign tx_accept = tx_push & ~tx_full;
  assign tx_data   = tx_mem[tx_rd_ptr_q];

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    overflow_d  = overflow_q | (tx_push & tx_full);
    if (tx_accept) begin
      tx_wr_ptr_d = tx_wr_ptr_q + TxPtrW'(1);
    end
    if (tx_pop) begin
      tx_rd_ptr_d = tx_rd_ptr_q + TxPtrW'(1);
    end
    case ({tx_accept, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + TxCntW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - TxCntW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (tx_accept) begin
      tx_mem[tx_wr_ptr_q] <= mem_dout;
    end
  end

  // Margin of two leaves room for a write already in flight when the CPU sees the flag.
  assign io_buffer_full = (tx_cnt_q >= TxAlmostCnt);
  assign overflow       = overflow_q;

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]        rx_mem [RX_DEPTH];
  logic [RxPtrW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [RxPtrW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RxCntW-1:0] rx_cnt_q, rx_cnt_d;
  logic              rx_nonempty;
  logic              rx_accept;
  logic              rx_pop;
  logic [7:0]        rx_head;

  assign rx_nonempty = (rx_cnt_q != '0);
  assign rx_ready    = (rx_cnt_q != RxFullCnt);
  assign rx_accept   = rx_valid & rx_ready;
  assign rx_pop      = rx_pop_req & rx_nonempty;
  assign rx_head     = rx_mem[rx_rd_ptr_q];

  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    if (rx_accept) begin
      rx_wr_ptr_d = rx_wr_ptr_q + RxPtrW'(1);
    end
    if (rx_pop) begin
      rx_rd_ptr_d = rx_rd_ptr_q + RxPtrW'(1);
    end
    case ({rx_accept, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + RxCntW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - RxCntW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rx_accept) begin
      rx_mem[rx_wr_ptr_q] <= rx_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle counter, snapshot and halt register
  // ---------------------------------------------------------------------------
  logic [31:0] cnt_q;
  logic [31:0] snap_q;
  logic        halt_q;
  logic [7:0]  halt_code_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      snap_q      <= '0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      if (snap_latch) begin
        snap_q <= cnt_q;
      end
      if (halt_wr) begin
        halt_q      <= 1'b1;
        halt_code_q <= mem_dout;
      end
    end
  end

  assign halt      = halt_q;
  assign halt_code = halt_code_q;

  // ---------------------------------------------------------------------------
  // Read data path
  // ---------------------------------------------------------------------------
  logic [7:0] io_rdata;
  logic [7:0] mem_din_q;

  always_comb begin
    io_rdata = 8'h00;
    case (io_reg)
      RegFifo:   io_rdata = rx_nonempty ? rx_head : 8'h00;
      RegStatus: io_rdata = {6'b0, tx_full, rx_nonempty};
      RegCnt0:   io_rdata = cnt_q[7:0];
      RegCnt1:   io_rdata = snap_q[15:8];
      RegCnt2:   io_rdata = snap_q[23:16];
      RegCnt3:   io_rdata = snap_q[31:24];
      default:   io_rdata = 8'h00;
    endcase
  end

  // Write cycles leave the previous read data in place.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mem_din_q <= '0;
    end else if (!mem_wr) begin
      mem_din_q <= is_io ? io_rdata : ram[ram_addr];
    end
  end

  assign mem_din = mem_din_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: read data and TX bytes are checked
// against scoreboard queues filled when the stimulus is driven.
module tb_cpu_mem_responder;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_a = 32'h0;
  logic [7:0]  mem_dout = 8'h0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        halt;
  logic [7:0]  halt_code;
  logic        overflow;

  cpu_mem_responder dut (
    .clk_in         (clk_in),
    .rst_n          (rst_n),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .halt           (halt),
    .halt_code      (halt_code),
    .overflow       (overflow)
  );

  always #5 clk_in = ~clk_in;

  int          checks = 0;
  int          failures = 0;
  int unsigned tb_cnt = 0;
  logic [7:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_b;

  task automatic tick();
    @(posedge clk_in);
    #1;
    tb_cnt++;
  endtask

  task automatic drive_rd(input logic [31:0] a, input logic [7:0] exp);
    mem_a = a; mem_wr = 1'b0; mem_dout = 8'h00;
    rd_q.push_back(exp);
  endtask

  task automatic drive_wr(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_wr = 1'b1; mem_dout = d;
  endtask

  task automatic drive_idle();
    mem_a = 32'h0000_0100; mem_wr = 1'b0; mem_dout = 8'h00;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tb_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_din, tx_valid, rx_ready, io_buffer_full, halt, halt_code, overflow} !==
        {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got din=%h txv=%b rxr=%b full=%b halt=%b code=%h ovf=%b",
               mem_din, tx_valid, rx_ready, io_buffer_full, halt, halt_code, overflow);
    end
  endtask

  task automatic test_ram();
    drive_wr(32'h0000_0010, 8'hA5); tick();
    drive_wr(32'h0001_FFFF, 8'h5A); tick();
    drive_wr(32'h0001_0002, 8'h33); tick();
    drive_wr(32'h0003_0002, 8'hEE); tick();  // ignored IO write, must not hit RAM
    drive_wr(32'h0000_0010, 8'hA5); tick();
    drive_rd(32'h0000_0010, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_b = rd_q.pop_front();
      checks++;
      if (mem_din !== exp_b) begin
        failures++;
        $display("FAIL ram_read[%0d]: got %h expected %h", i, mem_din, exp_b);
      end
      case (i)
        0: drive_rd(32'h0004_0010, 8'hA5);  // aliased address
        1: drive_rd(32'h0001_FFFF, 8'h5A);
        2: drive_rd(32'h0001_0002, 8'h33);
        default: drive_wr(32'h0000_0020, 8'h99);
      endcase
    end
    tick();
    checks++;
    if (mem_din !== 8'h33) begin
      failures++;
      $display("FAIL din_hold_on_write: got %h expected %h", mem_din, 8'h33);
    end
    drive_rd(32'h0003_0002, 8'h00);
    tick();
    exp_b = rd_q.pop_front();
    checks++;
    if (mem_din !== exp_b) begin
      failures++;
      $display("FAIL io_unmapped_read: got %h expected %h", mem_din, exp_b);
    end
    do_reset();
    checks++;
    if (mem_din !== 8'h00) begin
      failures++;
      $display("FAIL din_after_reset: got %h expected %h", mem_din, 8'h00);
    end
  endtask

  // Drains tx_q with tx_ready held high; bytes must appear on consecutive cycles.
  task automatic drain_tx(input string name);
    tx_ready = 1'b1;
    drive_idle();
    for (int c = 0; c < 20 && tx_q.size() > 0; c++) begin
      checks++;
      if (!tx_valid) begin
        failures++;
        $display("FAIL %s_gap: got tx_valid=0 expected 1 (%0d left)", name, tx_q.size());
      end else begin
        exp_b = tx_q.pop_front();
        if (tx_data !== exp_b) begin
          failures++;
          $display("FAIL %s_data: got %h expected %h", name, tx_data, exp_b);
        end
      end
      tick();
    end
    checks++;
    if (tx_q.size() != 0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_end: got left=%0d tx_valid=%b expected 0 and 0",
               name, tx_q.size(), tx_valid);
      tx_q.delete();
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_tx();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_wr(32'h0003_0000, 8'h41 + 8'(i));
      tx_q.push_back(8'h41 + 8'(i));
      tick();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
        failures++;
        $display("FAIL tx_head[%0d]: got v=%b d=%h expected v=1 d=41", i, tx_valid, tx_data);
      end
    end
    drain_tx("tx_basic");
  endtask

  task automatic test_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive_wr(32'h0003_0000, 8'h60 + 8'(i));
      if (i < 8) tx_q.push_back(8'h60 + 8'(i));
      tick();
      checks++;
      if (io_buffer_full !== (i >= 5) || overflow !== (i == 8)) begin
        failures++;
        $display("FAIL tx_fill[%0d]: got full=%b ovf=%b expected full=%b ovf=%b",
                 i, io_buffer_full, overflow, i >= 5, i == 8);
      end
    end
    drive_rd(32'h0003_0001, 8'h02);
    tick();
    exp_b = rd_q.pop_front();
    checks++;
    if (mem_din !== exp_b) begin
      failures++;
      $display("FAIL status_tx_full: got %h expected %h", mem_din, exp_b);
    end
    drain_tx("tx_ovf");
    checks++;
    if (overflow !== 1'b1 || io_buffer_full !== 1'b0) begin
      failures++;
      $display("FAIL ovf_sticky: got ovf=%b full=%b expected 1 0", overflow, io_buffer_full);
    end
  endtask

  task automatic test_rx();
    drive_idle();
    rx_valid = 1'b1;
    rx_data = 8'h11; tick();
    rx_data = 8'h22; tick();
    rx_valid = 1'b0;
    drive_rd(32'h0003_0001, 8'h01);
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_b = rd_q.pop_front();
      checks++;
      if (mem_din !== exp_b) begin
        failures++;
        $display("FAIL rx_read[%0d]: got %h expected %h", i, mem_din, exp_b);
      end
      case (i)
        0: drive_rd(32'h0003_0000, 8'h11);
        1: drive_rd(32'h0003_0000, 8'h22);
        2: drive_rd(32'h0003_0000, 8'h00);
        default: drive_idle();
      endcase
    end
    // Fill to capacity; the ninth byte must be refused.
    drive_idle();
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 8'h80 + 8'(i);
      tick();
    end
    rx_valid = 1'b0;
    checks++;
    if (rx_ready !== 1'b0) begin
      failures++;
      $display("FAIL rx_full: got rx_ready=%b expected 0", rx_ready);
    end
    drive_rd(32'h0003_0000, 8'h80);
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_b = rd_q.pop_front();
      checks++;
      if (mem_din !== exp_b) begin
        failures++;
        $display("FAIL rx_drain[%0d]: got %h expected %h", i, mem_din, exp_b);
      end
      if (i < 7) drive_rd(32'h0003_0000, 8'h81 + 8'(i));
      else if (i == 7) drive_rd(32'h0003_0000, 8'h00);
      else drive_idle();
    end
  endtask

  task automatic test_counter();
    do_reset();
    while (tb_cnt < 32'h0000_00FE) begin
      tick();
    end
    drive_rd(32'h0003_0004, 8'hFE);
    tick();
    exp_b = rd_q.pop_front();
    checks++;
    if (mem_din !== exp_b) begin
      failures++;
      $display("FAIL cnt_byte0: got %h expected %h", mem_din, exp_b);
    end
    drive_idle();
    tick();
    tick();
    drive_rd(32'h0003_0005, 8'h00);
    tick();
    exp_b = rd_q.pop_front();
    checks++;
    if (mem_din !== exp_b) begin
      failures++;
      $display("FAIL snap_byte1_fe: got %h expected %h", mem_din, exp_b);
    end
    drive_idle();
    while (tb_cnt < 32'h0000_0300) begin
      tick();
    end
    drive_rd(32'h0003_0004, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_b = rd_q.pop_front();
      checks++;
      if (mem_din !== exp_b) begin
        failures++;
        $display("FAIL snap_300[%0d]: got %h expected %h", i, mem_din, exp_b);
      end
      case (i)
        0: drive_rd(32'h0003_0005, 8'h03);
        1: drive_rd(32'h0003_0006, 8'h00);
        2: drive_rd(32'h0003_0007, 8'h00);
        default: drive_idle();
      endcase
    end
  endtask

  task automatic test_halt();
    drive_wr(32'h0003_0004, 8'h00);
    tick();
    checks++;
    if (halt !== 1'b1 || halt_code !== 8'h00) begin
      failures++;
      $display("FAIL halt_first: got halt=%b code=%h expected 1 00", halt, halt_code);
    end
    drive_wr(32'h0003_0004, 8'h07);
    tick();
    checks++;
    if (halt !== 1'b1 || halt_code !== 8'h07) begin
      failures++;
      $display("FAIL halt_second: got halt=%b code=%h expected 1 07", halt, halt_code);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_wr(32'h0003_0000, 8'hC0 + 8'(i));
      tick();
    end
    drive_idle();
    rx_valid = 1'b1; rx_data = 8'h5C; tick(); rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_valid, io_buffer_full, rx_ready, halt, overflow} !== 5'b00100) begin
      failures++;
      $display("FAIL async_reset: got txv=%b full=%b rxr=%b halt=%b ovf=%b expected 0 0 1 0 0",
               tx_valid, io_buffer_full, rx_ready, halt, overflow);
    end
    tick();
    rst_n = 1'b1;
    drive_rd(32'h0003_0000, 8'h00);
    tick();
    exp_b = rd_q.pop_front();
    checks++;
    if (mem_din !== exp_b) begin
      failures++;
      $display("FAIL rx_flushed: got %h expected %h", mem_din, exp_b);
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_ram();
    test_tx();
    test_overflow();
    test_rx();
    test_counter();
    test_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
